// File: rtl/lane_rt_pkg.sv
// lane_rt_pkg
// Shared types and constants for the lane read-training sequencer.
//   lane_rt_state_e : sequencer / sampler state encoding
//   tap_result_e    : per-tap pass/fail encoding
//   MOVE_GAP        : minimum spacing, in cycles, between DELAY_LINE_MOVE pulses
//   SMP_CNT_W       : width of the settle/sample down-counter
package lane_rt_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_LOAD   = 4'd1,
    S_CLEAR  = 4'd2,
    S_SETTLE = 4'd3,
    S_SAMPLE = 4'd4,
    S_EVAL   = 4'd5,
    S_STEP   = 4'd6,
    S_CENTER = 4'd7,
    S_FIN    = 4'd8,
    S_FAIL   = 4'd9
  } lane_rt_state_e;

  typedef enum logic {
    TAP_PASS = 1'b0,
    TAP_FAIL = 1'b1
  } tap_result_e;

  localparam int MOVE_GAP  = 2;
  localparam int SMP_CNT_W = 8;

endpackage

// File: rtl/lane_rt_eye_sampler.sv
// lane_rt_eye_sampler
// Runs one tap observation: clears the IOD eye-monitor flags, waits for the
// flags to settle, then ORs EARLY|LATE (and delay-line saturation) over the
// sample window.
// Ports:
//   clk_sys, rst_b : clock, synchronous active-low reset
//   start_i        : launch one observation (CLEAR follows on the next cycle)
//   early_i/late_i : IOD eye-monitor flags
//   oor_i          : IOD delay-line out-of-range
//   clear_o        : registered one-cycle EYE_MONITOR_CLEAR_FLAGS pulse
//   done_o         : high in the last SAMPLE cycle
//   result_o       : tap pass/fail, valid with done_o (includes that cycle)
//   oor_o          : out-of-range seen in the window, valid with done_o
module lane_rt_eye_sampler
  import lane_rt_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_CYC = 16
) (
  input  logic        clk_sys,
  input  logic        rst_b,
  input  logic        start_i,
  input  logic        early_i,
  input  logic        late_i,
  input  logic        oor_i,
  output logic        clear_o,
  output logic        done_o,
  output tap_result_e result_o,
  output logic        oor_o
);

  localparam logic [SMP_CNT_W-1:0] SETTLE_LAST = SMP_CNT_W'(SETTLE_CYC - 1);
  localparam logic [SMP_CNT_W-1:0] SAMPLE_LAST = SMP_CNT_W'(SAMPLE_CYC - 1);

  lane_rt_state_e       phase_q, phase_d;
  logic [SMP_CNT_W-1:0] cnt_q, cnt_d;
  logic                 clear_q, clear_d;
  logic                 fail_q, fail_d;
  logic                 oor_q, oor_d;

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    clear_d = 1'b0;
    fail_d  = fail_q;
    oor_d   = oor_q;
    case (phase_q)
      S_CLEAR: begin
        phase_d = S_SETTLE;
        cnt_d   = SETTLE_LAST;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          phase_d = S_SAMPLE;
          cnt_d   = SAMPLE_LAST;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SAMPLE: begin
        fail_d = fail_q | early_i | late_i;
        oor_d  = oor_q | oor_i;
        if (cnt_q == '0) phase_d = S_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if (start_i) begin
          phase_d = S_CLEAR;
          clear_d = 1'b1;
          fail_d  = 1'b0;
          oor_d   = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      phase_q <= S_IDLE;
      cnt_q   <= '0;
      clear_q <= 1'b0;
      fail_q  <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      clear_q <= clear_d;
      fail_q  <= fail_d;
      oor_q   <= oor_d;
    end
  end

  // Result folds in the final sample cycle so EVAL can follow immediately.
  assign clear_o  = clear_q;
  assign done_o   = (phase_q == S_SAMPLE) && (cnt_q == '0);
  assign result_o = (fail_q | early_i | late_i) ? TAP_FAIL : TAP_PASS;
  assign oor_o    = oor_q | oor_i;

endmodule

// File: rtl/lane_read_training_ctrl.sv
// lane_read_training_ctrl
// Per-lane DDR4 read-training sequencer: sweeps the IOD input delay line,
// finds the first passing window of at least MIN_EYE taps and parks the
// delay line at its centre.
// Build option: LANE_RT_RETRY_EN -- a failed sweep is retried once before ERR.
// Ports:
//   FAB_CLK, RESET_N            : clock, synchronous active-low reset
//   START                       : one-cycle training request (ignored while BUSY)
//   EYE_MONITOR_EARLY/LATE      : IOD eye-monitor flags
//   DELAY_LINE_OUT_OF_RANGE     : IOD delay-line saturation
//   DELAY_LINE_MOVE/DIRECTION   : tap move pulse, 1 = increment
//   DELAY_LINE_LOAD             : reload delay line to tap 0
//   EYE_MONITOR_CLEAR_FLAGS     : flag clear pulse
//   BUSY, DONE, ERR             : status (DONE/ERR sticky until next START)
//   TAP_CENTER, EYE_WIDTH       : training result
//
// state    | meaning
// S_IDLE   | waiting for START
// S_LOAD   | delay line reloaded to tap 0, counters zeroed
// S_SAMPLE | eye sampler running its CLEAR / SETTLE / SAMPLE phases
// S_EVAL   | fold tap result into the eye search
// S_STEP   | move delay line up one tap
// S_CENTER | walk delay line down to the eye centre
// S_FIN    | success, result latched
// S_FAIL   | no valid eye found
module lane_read_training_ctrl
  import lane_rt_pkg::*;
#(
  parameter int TAP_MAX    = 127,
  parameter int DLY_W      = 8,
  parameter int SETTLE_CYC = 4,
  parameter int SAMPLE_CYC = 16,
  parameter int MIN_EYE    = 8
) (
  input  logic             FAB_CLK,
  input  logic             RESET_N,
  input  logic             START,
  input  logic             EYE_MONITOR_EARLY,
  input  logic             EYE_MONITOR_LATE,
  input  logic             DELAY_LINE_OUT_OF_RANGE,
  output logic             DELAY_LINE_MOVE,
  output logic             DELAY_LINE_DIRECTION,
  output logic             DELAY_LINE_LOAD,
  output logic             EYE_MONITOR_CLEAR_FLAGS,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [DLY_W-1:0] TAP_CENTER,
  output logic [DLY_W-1:0] EYE_WIDTH
);

`ifdef LANE_RT_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  localparam logic [DLY_W-1:0] TAP_LAST = DLY_W'(TAP_MAX);
  localparam logic [DLY_W-1:0] MIN_W    = DLY_W'(MIN_EYE);
  localparam logic [1:0]       GAP_LOAD = 2'(MOVE_GAP - 1);

  lane_rt_state_e   state_q, state_d;
  logic [DLY_W-1:0] tap_q, tap_d;
  logic [DLY_W-1:0] left_q, left_d;
  logic [DLY_W-1:0] width_q, width_d;
  tap_result_e      tap_res_q, tap_res_d;
  logic             tap_oor_q, tap_oor_d;
  logic [1:0]       gap_q, gap_d;
  logic             retry_q, retry_d;
  logic             move_q, move_d;
  logic             dir_q, dir_d;
  logic             load_q, load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DLY_W-1:0] tap_center_q, tap_center_d;
  logic [DLY_W-1:0] eye_width_q, eye_width_d;

  logic             smp_start;
  logic             smp_done;
  tap_result_e      smp_result;
  logic             smp_oor;

  logic [DLY_W-1:0] ev_left, ev_width, center_tgt;
  logic             ev_found, ev_end, ev_eye_ok;

  lane_rt_eye_sampler #(
    .SETTLE_CYC (SETTLE_CYC),
    .SAMPLE_CYC (SAMPLE_CYC)
  ) u_sampler (
    .clk_sys  (FAB_CLK),
    .rst_b    (RESET_N),
    .start_i  (smp_start),
    .early_i  (EYE_MONITOR_EARLY),
    .late_i   (EYE_MONITOR_LATE),
    .oor_i    (DELAY_LINE_OUT_OF_RANGE),
    .clear_o  (EYE_MONITOR_CLEAR_FLAGS),
    .done_o   (smp_done),
    .result_o (smp_result),
    .oor_o    (smp_oor)
  );

  // Width cannot exceed TAP_MAX+1, so left + width/2 stays within DLY_W.
  assign center_tgt = left_q + (width_q >> 1);

  // Eye search update for the tap just sampled. A failing tap that closes a
  // wide-enough window ends the search with the window unchanged.
  always_comb begin
    ev_left  = left_q;
    ev_width = width_q;
    ev_found = 1'b0;
    if (tap_res_q == TAP_PASS) begin
      if (width_q == '0) ev_left = tap_q;
      ev_width = width_q + 1'b1;
    end else if (width_q >= MIN_W) begin
      ev_found = 1'b1;
    end else begin
      ev_width = '0;
    end
    ev_end    = (tap_q == TAP_LAST) || tap_oor_q;
    ev_eye_ok = ev_found || (ev_end && (ev_width >= MIN_W));
  end

  always_comb begin
    state_d      = state_q;
    tap_d        = tap_q;
    left_d       = left_q;
    width_d      = width_q;
    tap_res_d    = tap_res_q;
    tap_oor_d    = tap_oor_q;
    gap_d        = gap_q;
    retry_d      = retry_q;
    done_d       = done_q;
    err_d        = err_q;
    tap_center_d = tap_center_q;
    eye_width_d  = eye_width_q;
    move_d       = 1'b0;
    dir_d        = 1'b0;
    smp_start    = 1'b0;
    case (state_q)
      S_LOAD: begin
        tap_d     = '0;
        left_d    = '0;
        width_d   = '0;
        smp_start = 1'b1;
        state_d   = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (smp_done) begin
          tap_res_d = smp_result;
          tap_oor_d = smp_oor;
          state_d   = S_EVAL;
        end
      end
      S_EVAL: begin
        left_d  = ev_left;
        width_d = ev_width;
        if (ev_eye_ok) begin
          gap_d   = '0;
          state_d = S_CENTER;
        end else if (ev_end) begin
          if (RETRY_EN && !retry_q) begin
            retry_d = 1'b1;
            state_d = S_LOAD;
          end else begin
            err_d        = 1'b1;
            tap_center_d = '0;
            eye_width_d  = '0;
            state_d      = S_FAIL;
          end
        end else begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        tap_d     = tap_q + 1'b1;
        smp_start = 1'b1;
        state_d   = S_SAMPLE;
      end
      S_CENTER: begin
        // gap_q enforces the MOVE spacing between downward pulses.
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (tap_q > center_tgt) begin
          move_d = 1'b1;
          tap_d  = tap_q - 1'b1;
          gap_d  = GAP_LOAD;
        end else begin
          done_d       = 1'b1;
          tap_center_d = tap_q;
          eye_width_d  = width_q;
          state_d      = S_FIN;
        end
      end
      S_IDLE, S_FIN, S_FAIL: begin
        if (START) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          retry_d = 1'b0;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_STEP) begin
      move_d = 1'b1;
      dir_d  = 1'b1;
    end
  end

  // Pulse and status outputs are derived from the state being entered so
  // they line up with that state's cycle.
  assign load_d = (state_d == S_LOAD);
  assign busy_d = !(state_d inside {S_IDLE, S_FIN, S_FAIL});

  always_ff @(posedge FAB_CLK) begin
    if (!RESET_N) begin
      state_q      <= S_IDLE;
      tap_q        <= '0;
      left_q       <= '0;
      width_q      <= '0;
      tap_res_q    <= TAP_PASS;
      tap_oor_q    <= 1'b0;
      gap_q        <= '0;
      retry_q      <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      tap_center_q <= '0;
      eye_width_q  <= '0;
    end else begin
      state_q      <= state_d;
      tap_q        <= tap_d;
      left_q       <= left_d;
      width_q      <= width_d;
      tap_res_q    <= tap_res_d;
      tap_oor_q    <= tap_oor_d;
      gap_q        <= gap_d;
      retry_q      <= retry_d;
      move_q       <= move_d;
      dir_q        <= dir_d;
      load_q       <= load_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      tap_center_q <= tap_center_d;
      eye_width_q  <= eye_width_d;
    end
  end

  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign BUSY                 = busy_q;
  assign DONE                 = done_q;
  assign ERR                  = err_q;
  assign TAP_CENTER           = tap_center_q;
  assign EYE_WIDTH            = eye_width_q;

endmodule
